// File: rtl/rect_cmd_sequencer.sv
// rect_cmd_sequencer
//   Command front end for flip_controller. Collects a 7-byte rectangle-flip
//   frame (0xA5, ADDR, R1, R2, C1, C2, CHK) from a valid/ready byte stream,
//   validates checksum and coordinate range, then presents the command with
//   a one-cycle start pulse and waits for done (or a timeout).
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | hunting for the 0xA5 header, other bytes dropped
//   COLLECT   | capturing the 6 payload bytes (0xA5 here is plain data)
//   CHECK     | one cycle: checksum then range validation
//   ISSUE     | one cycle: start pulse, timeout counter cleared
//   WAIT_DONE | waiting for done; aborts after TIMEOUT cycles
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   in_valid/in_data      byte stream in; in_ready = byte accepted
//   done                  completion from flip_controller
//   start                 one-cycle command strobe
//   base_addr,r1,r2,c1,c2 latched command, stable from ISSUE to next good CHECK
//   busy                  high in CHECK, ISSUE, WAIT_DONE
//   cmd_ok, cmd_err       one-cycle completion / reject-or-abort pulses
//   err_code              sticky: 0 none, 1 checksum, 2 range, 3 timeout
//   cmd_count             completed commands, wrapping
module rect_cmd_sequencer #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255,
  localparam int RW        = $clog2(ROWS),
  localparam int CW        = $clog2(COLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  done,
  output logic                  start,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic [RW-1:0]         r1,
  output logic [RW-1:0]         r2,
  output logic [CW-1:0]         c1,
  output logic [CW-1:0]         c2,
  output logic                  busy,
  output logic                  cmd_ok,
  output logic                  cmd_err,
  output logic [1:0]            err_code,
  output logic [15:0]           cmd_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] ROWS_B = 8'(ROWS);
  localparam logic [7:0] COLS_B = 8'(COLS);

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, ISSUE, WAIT_DONE} state_t;

  state_t state_q, state_d;

  logic [2:0]    idx_q;
  logic [7:0]    addr_q, r1_q, r2_q, c1_q, c2_q, chk_q;
  logic [TW-1:0] tmo_q;

  logic accept, chk_fail, range_fail, tmo_hit;

  // Upper coordinate bits are compared too, so out-of-width values are caught.
  assign chk_fail   = (addr_q ^ r1_q ^ r2_q ^ c1_q ^ c2_q) != chk_q;
  assign range_fail = (r1_q >= ROWS_B) || (r2_q >= ROWS_B) ||
                      (c1_q >= COLS_B) || (c2_q >= COLS_B) ||
                      (r1_q > r2_q) || (c1_q > c2_q) ||
                      ((addr_q >> ADDR_WIDTH) != 8'd0);
  // The counter starts at 0 on the first WAIT_DONE cycle, so TIMEOUT-1 marks
  // the TIMEOUT-th cycle after ISSUE.
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));

  // in_ready is gated by reset so every output reads 0 while reset is held.
  assign in_ready = !busy && !reset;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    busy    = 1'b0;
    cmd_ok  = 1'b0;
    cmd_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && in_data == 8'hA5) state_d = COLLECT;
      end
      COLLECT: begin
        if (accept && idx_q == 3'd5) state_d = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (chk_fail || range_fail) begin
          cmd_err = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        start   = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (done) begin
          cmd_ok  = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          cmd_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      addr_q    <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      base_addr <= '0;
      r1        <= '0;
      r2        <= '0;
      c1        <= '0;
      c2        <= '0;
      err_code  <= 2'd0;
      cmd_count <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) idx_q <= 3'd0;
        end
        COLLECT: begin
          if (accept) begin
            idx_q <= idx_q + 3'd1;
            case (idx_q)
              3'd0:    addr_q <= in_data;
              3'd1:    r1_q   <= in_data;
              3'd2:    r2_q   <= in_data;
              3'd3:    c1_q   <= in_data;
              3'd4:    c2_q   <= in_data;
              default: chk_q  <= in_data;
            endcase
          end
        end
        CHECK: begin
          if (chk_fail) begin
            err_code <= 2'd1;
          end else if (range_fail) begin
            err_code <= 2'd2;
          end else begin
            base_addr <= addr_q[ADDR_WIDTH-1:0];
            r1        <= r1_q[RW-1:0];
            r2        <= r2_q[RW-1:0];
            c1        <= c1_q[CW-1:0];
            c2        <= c2_q[CW-1:0];
          end
        end
        ISSUE: begin
          tmo_q <= '0;
        end
        WAIT_DONE: begin
          tmo_q <= tmo_q + TW'(1);
          if (done) begin
            cmd_count <= cmd_count + 16'd1;
            err_code  <= 2'd0;
          end else if (tmo_hit) begin
            err_code <= 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
